load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage between the ALU (effective-address generation) and register write-back. Accepts one load or store per request and drives a 64-bit-wide synchronous data RAM with byte enables. Accesses that straddle a doubleword boundary are split into two RAM beats. Load results are returned fully zero- or sign-extended to 64 bits, ready for the write-back path.

## Interface
**Parameters**
- ADDR_W, 16, width of the byte address. RAM index width is ADDR_W-3.

**Ports**
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE. Transfer when req_valid && req_ready.
- req_po  in  6  primary opcode: 34 lbz, 40 lhz, 42 lha, 32 lwz, 58 ld, 38 stb, 44 sth, 36 stw, 62 std. DS sub-opcode bits are stripped upstream.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  single-cycle completion pulse. No backpressure.
- resp_rdata  out  64  extended load data. 0 for stores and errors.
- resp_err  out  1  valid with resp_valid. Set for an unsupported po.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  write when mem_en is high.
- mem_addr  out  ADDR_W-3  doubleword index.
- mem_be  out  8  byte enables. Bit i = byte i, little-endian.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data, valid the cycle after a read strobe.

## Operation
- Size from po: 1 (34/38), 2 (40/42/44), 4 (32/36), 8 (58/62). lha sign-extends. All other loads zero-extend.
- off = addr[2:0]. split = (off + size) > 8.
- Beat0 index = addr[ADDR_W-1:3]. Beat1 index = beat0 + 1, modulo 2^(ADDR_W-3), so it wraps to 0.
- Byte enables: 16-bit mask m = ((1<<size)-1) << off. Beat0 uses m[7:0], beat1 uses m[15:8].
- Store data: 128-bit value w = req_wdata << (8*off). Beat0 writes w[63:0], beat1 writes w[127:64].
- Load data: {rd1, rd0} >> (8*off), truncated to size, then extended. rd1 = 0 when not split.
- States:
  - IDLE: on accept, register po, addr, wdata. Legal po goes to BEAT0, illegal po goes to DONE.
  - BEAT0: mem_en=1. Load goes to RD0. Store goes to BEAT1 if split, else DONE.
  - RD0: capture rd0. Goes to BEAT1 if split, else DONE.
  - BEAT1: mem_en=1. Load goes to RD1, store goes to DONE.
  - RD1: capture rd1, then DONE.
  - DONE: resp_valid=1, then IDLE.
- Outside BEAT0/BEAT1, mem_en, mem_we, mem_be, mem_addr and mem_wdata are all 0.

## Timing
- Request accepted at edge T. Latencies:
  - Aligned load: resp at T+3.
  - Split load: T+5.
  - Aligned store: T+2.
  - Split store: T+3.
  - Illegal po: T+1.
- Throughput is one request in flight. The next accept happens in the cycle after DONE.
- Reset values: state IDLE, req_ready 1, all other outputs 0, capture registers 0.
- Reset mid-operation aborts at once. No response is produced and no retry occurs. A split store may leave beat0 written; this is accepted behaviour.
- A req_valid held during a busy period is ignored until IDLE.

## Structure
- Package lsu_pkg holds:
  - po constants;
  - a size enum (SZ_B/H/W/D);
  - the state enum;
  - a function mapping po to {legal, is_store, size, sign}.
- Sub-module lsu_align (combinational) contains the mask, store shift and load extract/extend logic. load_store_unit keeps the FSM and registers.

## Test plan
- Aligned ld: mem[2] = 0x1122334455667788, ld at 0x0010 → one read of index 2, be 0xFF; resp_rdata 0x1122334455667788 at T+3.
- Halfword extension: mem[0] = 0x8001000000000000 at addr 0x0006.
  - lha → 0xFFFFFFFFFFFF8001.
  - lhz → 0x0000000000008001.
- Split stw: 0xAABBCCDD at 0x000E → beat0 idx 1, be 0xC0, wdata 0xCCDD000000000000; beat1 idx 2, be 0x03, wdata 0x000000000000AABB; resp at T+3.
- Split ld with wrap: mem[0] = 0x0706050403020100, mem[1] = 0x0F0E0D0C0B0A0908.
  - ld at 0x0005 → 0x0C0B0A0908070605 at T+5.
  - ld at 0xFFFE → beat1 index 0.
- Illegal po 0 → resp_valid with resp_err=1 at T+1; mem_en never asserted.
- rst_n low during RD0 → no resp_valid; req_ready=1 after release; following lbz completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: opcode constants, access size,
// FSM states and the opcode decoder.
package lsu_pkg;

  localparam logic [5:0] PO_LBZ = 6'd34;
  localparam logic [5:0] PO_LHZ = 6'd40;
  localparam logic [5:0] PO_LHA = 6'd42;
  localparam logic [5:0] PO_LWZ = 6'd32;
  localparam logic [5:0] PO_LD  = 6'd58;
  localparam logic [5:0] PO_STB = 6'd38;
  localparam logic [5:0] PO_STH = 6'd44;
  localparam logic [5:0] PO_STW = 6'd36;
  localparam logic [5:0] PO_STD = 6'd62;

  // Encoded as log2 of the byte count.
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_BEAT0, ST_RD0, ST_BEAT1, ST_RD1, ST_DONE
  } state_e;

  typedef struct packed {
    logic  legal;
    logic  is_store;
    size_e size;
    logic  sign;
  } po_info_t;

  function automatic po_info_t decode_po(input logic [5:0] po);
    po_info_t info;
    info.legal    = 1'b1;
    info.is_store = 1'b0;
    info.size     = SZ_B;
    info.sign     = 1'b0;
    case (po)
      PO_LBZ: info.size = SZ_B;
      PO_LHZ: info.size = SZ_H;
      PO_LHA: begin info.size = SZ_H; info.sign = 1'b1; end
      PO_LWZ: info.size = SZ_W;
      PO_LD:  info.size = SZ_D;
      PO_STB: begin info.size = SZ_B; info.is_store = 1'b1; end
      PO_STH: begin info.size = SZ_H; info.is_store = 1'b1; end
      PO_STW: begin info.size = SZ_W; info.is_store = 1'b1; end
      PO_STD: begin info.size = SZ_D; info.is_store = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment: byte-enable mask, store data shift and
// load data extraction with zero/sign extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]   off,
  input  size_e        size,
  input  logic         sign,
  input  logic [63:0]  wdata,
  input  logic [63:0]  rd0,
  input  logic [63:0]  rd1,
  output logic         split,
  output logic [15:0]  mask,
  output logic [127:0] wshift,
  output logic [63:0]  rdata
);

  logic [3:0]  nbytes;
  logic [63:0] raw;

  always_comb begin
    nbytes = 4'd1 << size;
    split  = ({1'b0, off} + nbytes) > 4'd8;
    mask   = ((16'd1 << nbytes) - 16'd1) << off;
    wshift = {64'd0, wdata} << {off, 3'b000};
    raw    = 64'({rd1, rd0} >> {off, 3'b000});
    case (size)
      SZ_B:    rdata = {56'd0, raw[7:0]};
      SZ_H:    rdata = sign ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      SZ_W:    rdata = {32'd0, raw[31:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one request in flight, doubleword-crossing accesses
// split into two RAM beats, load results extended to 64 bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_po,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [7:0]        mem_be,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic [5:0]          po_q, po_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         rd0_q, rd0_d;
  logic [63:0]         rd1_q, rd1_d;

  po_info_t            info_q, info_in;
  logic                accept;
  logic                split;
  logic [15:0]         mask;
  logic [127:0]        wshift;
  logic [63:0]         ext_rdata;
  logic [ADDR_W-4:0]   idx0, idx1;

  always_comb begin
    info_in = decode_po(req_po);
    info_q  = decode_po(po_q);
    accept  = req_valid && (state_q == ST_IDLE);
    idx0    = addr_q[ADDR_W-1:3];
    idx1    = idx0 + {{(ADDR_W-4){1'b0}}, 1'b1};
  end

  lsu_align u_align (
    .off    (addr_q[2:0]),
    .size   (info_q.size),
    .sign   (info_q.sign),
    .wdata  (wdata_q),
    .rd0    (rd0_q),
    .rd1    (rd1_q),
    .split  (split),
    .mask   (mask),
    .wshift (wshift),
    .rdata  (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      po_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = info_in.legal ? ST_BEAT0 : ST_DONE;
      ST_BEAT0: state_d = !info_q.is_store ? ST_RD0 : (split ? ST_BEAT1 : ST_DONE);
      ST_RD0:   state_d = split ? ST_BEAT1 : ST_DONE;
      ST_BEAT1: state_d = info_q.is_store ? ST_DONE : ST_RD1;
      ST_RD1:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rd1 is cleared on accept so an unsplit load sees zero in the upper half.
  always_comb begin
    po_d    = po_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    if (accept) begin
      po_d    = req_po;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      rd0_d   = '0;
      rd1_d   = '0;
    end
    if (state_q == ST_RD0) rd0_d = mem_rdata;
    if (state_q == ST_RD1) rd1_d = mem_rdata;
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_BEAT0: begin
        mem_en    = 1'b1;
        mem_we    = info_q.is_store;
        mem_addr  = idx0;
        mem_be    = mask[7:0];
        mem_wdata = info_q.is_store ? wshift[63:0] : '0;
      end
      ST_BEAT1: begin
        mem_en    = 1'b1;
        mem_we    = info_q.is_store;
        mem_addr  = idx1;
        mem_be    = mask[15:8];
        mem_wdata = info_q.is_store ? wshift[127:64] : '0;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = !info_q.legal;
        resp_rdata = (info_q.legal && !info_q.is_store) ? ext_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level
// memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_po = '0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_po     (req_po),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous data RAM seen by the DUT.
  logic [63:0] ram [0:8191];
  logic [63:0] ram_rdata = '0;
  assign mem_rdata = ram_rdata;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 8; i++)
          if (mem_be[i]) ram[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
      end else begin
        ram_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_mem [0:65535];

  int errors = 0;
  int checks = 0;

  int          obs_lat, obs_nbeats;
  logic [63:0] obs_rdata;
  logic        obs_err;
  logic [12:0] obs_idx [4];
  logic [7:0]  obs_be [4];
  logic        obs_we [4];
  logic [63:0] obs_wd [4];

  int          e_lat, e_nbeats;
  logic [63:0] e_rdata;
  logic        e_err, e_store;
  logic [12:0] e_idx0, e_idx1;
  logic [7:0]  e_be0, e_be1;

  function automatic logic [63:0] ref_dw(input int idx);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_mem[idx*8 + b];
    return v;
  endfunction

  task automatic set_dw(input int idx, input logic [63:0] v);
    ram[idx] = v;
    for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = v[8*b +: 8];
  endtask

  task automatic model_info(input logic [5:0] po, output logic legal, output logic st,
                            output int size, output logic sgn);
    legal = 1'b1; st = 1'b0; size = 1; sgn = 1'b0;
    case (po)
      6'd34: size = 1;
      6'd40: size = 2;
      6'd42: begin size = 2; sgn = 1'b1; end
      6'd32: size = 4;
      6'd58: size = 8;
      6'd38: begin size = 1; st = 1'b1; end
      6'd44: begin size = 2; st = 1'b1; end
      6'd36: begin size = 4; st = 1'b1; end
      6'd62: begin size = 8; st = 1'b1; end
      default: legal = 1'b0;
    endcase
  endtask

  // Predict the outcome of one request and apply stores to the byte model.
  task automatic model_op(input logic [5:0] po, input logic [15:0] addr, input logic [63:0] wd);
    logic legal, sgn;
    int size;
    logic [15:0] a, last;
    model_info(po, legal, e_store, size, sgn);
    e_err = !legal; e_rdata = '0; e_nbeats = 0; e_be0 = '0; e_be1 = '0;
    e_idx0 = '0; e_idx1 = '0;
    if (!legal) begin
      e_lat = 1;
    end else begin
      last   = addr + 16'(size - 1);
      e_idx0 = addr[15:3];
      e_idx1 = last[15:3];
      e_nbeats = (e_idx0 != e_idx1) ? 2 : 1;
      for (int k = 0; k < size; k++) begin
        a = addr + 16'(k);
        if (a[15:3] == e_idx0) e_be0[a[2:0]] = 1'b1;
        else                   e_be1[a[2:0]] = 1'b1;
      end
      if (e_store) begin
        for (int k = 0; k < size; k++) begin
          a = addr + 16'(k);
          ref_mem[a] = wd[8*k +: 8];
        end
        e_lat = (e_nbeats == 2) ? 3 : 2;
      end else begin
        for (int k = 0; k < size; k++) begin
          a = addr + 16'(k);
          e_rdata[8*k +: 8] = ref_mem[a];
        end
        if (sgn && e_rdata[8*size-1])
          for (int b = size; b < 8; b++) e_rdata[8*b +: 8] = 8'hFF;
        e_lat = (e_nbeats == 2) ? 5 : 3;
      end
    end
  endtask

  // Issue one request and record beats and the response (bounded wait).
  task automatic do_op(input logic [5:0] po, input logic [15:0] addr, input logic [63:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_po = po; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    obs_lat = 0; obs_nbeats = 0; obs_rdata = 'x; obs_err = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_en && obs_nbeats < 4) begin
        obs_idx[obs_nbeats] = mem_addr; obs_be[obs_nbeats] = mem_be;
        obs_we[obs_nbeats] = mem_we; obs_wd[obs_nbeats] = mem_wdata;
        obs_nbeats++;
      end
      if (resp_valid) begin
        obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: rdata=%h err=%b want 0", resp_rdata, resp_err); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin errors++;
      $display("FAIL reset_mem: en=%b we=%b addr=%h be=%h wd=%h want all 0", mem_en, mem_we, mem_addr, mem_be, mem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_ld;
    set_dw(2, 64'h1122334455667788);
    model_op(6'd58, 16'h0010, '0);
    do_op(6'd58, 16'h0010, '0);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL ald_latency: got %0d want 3", obs_lat); end
    checks++; if (obs_nbeats !== 1 || obs_idx[0] !== 13'd2 || obs_be[0] !== 8'hFF || obs_we[0] !== 1'b0) begin errors++;
      $display("FAIL ald_beat: n=%0d idx=%h be=%h we=%b want 1/2/ff/0", obs_nbeats, obs_idx[0], obs_be[0], obs_we[0]); end
    checks++; if (obs_rdata !== 64'h1122334455667788 || obs_rdata !== e_rdata) begin errors++;
      $display("FAIL ald_data: got %h want 1122334455667788", obs_rdata); end
  endtask

  task automatic test_half_ext;
    set_dw(0, 64'h8001000000000000);
    model_op(6'd42, 16'h0006, '0);
    do_op(6'd42, 16'h0006, '0);
    checks++; if (obs_rdata !== 64'hFFFFFFFFFFFF8001 || obs_rdata !== e_rdata) begin errors++;
      $display("FAIL lha_ext: got %h want ffffffffffff8001", obs_rdata); end
    model_op(6'd40, 16'h0006, '0);
    do_op(6'd40, 16'h0006, '0);
    checks++; if (obs_rdata !== 64'h0000000000008001 || obs_rdata !== e_rdata) begin errors++;
      $display("FAIL lhz_ext: got %h want 0000000000008001", obs_rdata); end
  endtask

  task automatic test_split_stw;
    model_op(6'd36, 16'h000E, 64'h00000000AABBCCDD);
    do_op(6'd36, 16'h000E, 64'h00000000AABBCCDD);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL sstw_latency: got %0d want 3", obs_lat); end
    checks++; if (obs_nbeats !== 2) begin errors++; $display("FAIL sstw_nbeats: got %0d want 2", obs_nbeats); end
    checks++; if (obs_idx[0] !== 13'd1 || obs_be[0] !== 8'hC0 || obs_wd[0] !== 64'hCCDD000000000000 || obs_we[0] !== 1'b1) begin errors++;
      $display("FAIL sstw_beat0: idx=%h be=%h wd=%h we=%b want 1/c0/ccdd000000000000/1", obs_idx[0], obs_be[0], obs_wd[0], obs_we[0]); end
    checks++; if (obs_idx[1] !== 13'd2 || obs_be[1] !== 8'h03 || obs_wd[1] !== 64'h000000000000AABB || obs_we[1] !== 1'b1) begin errors++;
      $display("FAIL sstw_beat1: idx=%h be=%h wd=%h we=%b want 2/03/000000000000aabb/1", obs_idx[1], obs_be[1], obs_wd[1], obs_we[1]); end
    checks++; if (ram[1] !== ref_dw(1) || ram[2] !== ref_dw(2)) begin errors++;
      $display("FAIL sstw_ram: got %h %h want %h %h", ram[1], ram[2], ref_dw(1), ref_dw(2)); end
    checks++; if (obs_rdata !== 64'd0 || obs_err !== 1'b0) begin errors++;
      $display("FAIL sstw_resp: rdata=%h err=%b want 0/0", obs_rdata, obs_err); end
  endtask

  task automatic test_split_ld_wrap;
    set_dw(0, 64'h0706050403020100);
    set_dw(1, 64'h0F0E0D0C0B0A0908);
    model_op(6'd58, 16'h0005, '0);
    do_op(6'd58, 16'h0005, '0);
    checks++; if (obs_lat !== 5) begin errors++; $display("FAIL sld_latency: got %0d want 5", obs_lat); end
    checks++; if (obs_rdata !== 64'h0C0B0A0908070605 || obs_rdata !== e_rdata) begin errors++;
      $display("FAIL sld_data: got %h want 0c0b0a0908070605", obs_rdata); end
    model_op(6'd58, 16'hFFFE, '0);
    do_op(6'd58, 16'hFFFE, '0);
    checks++; if (obs_nbeats !== 2 || obs_idx[0] !== 13'h1FFF || obs_idx[1] !== 13'd0) begin errors++;
      $display("FAIL wrap_beats: n=%0d idx0=%h idx1=%h want 2/1fff/0", obs_nbeats, obs_idx[0], obs_idx[1]); end
    checks++; if (obs_be[0] !== 8'hC0 || obs_be[1] !== 8'h3F) begin errors++;
      $display("FAIL wrap_be: be0=%h be1=%h want c0/3f", obs_be[0], obs_be[1]); end
    checks++; if (obs_rdata !== e_rdata) begin errors++; $display("FAIL wrap_data: got %h want %h", obs_rdata, e_rdata); end
  endtask

  task automatic test_illegal;
    do_op(6'd0, 16'h0123, 64'hDEAD);
    checks++; if (obs_lat !== 1 || obs_err !== 1'b1) begin errors++;
      $display("FAIL illegal_resp: lat=%0d err=%b want 1/1", obs_lat, obs_err); end
    checks++; if (obs_nbeats !== 0 || obs_rdata !== 64'd0) begin errors++;
      $display("FAIL illegal_mem: beats=%0d rdata=%h want 0/0", obs_nbeats, obs_rdata); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    req_valid = 1'b1; req_po = 6'd34; req_addr = 16'h0040; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    repeat (2) begin #1; if (resp_valid) pulses++; @(negedge clk); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    repeat (6) begin @(negedge clk); if (resp_valid) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_noresp: got %0d pulses want 0", pulses); end
    model_op(6'd34, 16'h0043, '0);
    do_op(6'd34, 16'h0043, '0);
    checks++; if (obs_lat !== 3 || obs_rdata !== e_rdata || obs_err !== 1'b0) begin errors++;
      $display("FAIL rstmid_lbz: lat=%0d rdata=%h err=%b want 3/%h/0", obs_lat, obs_rdata, obs_err, e_rdata); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    int at [4];
    pulses = 0;
    model_op(6'd34, 16'h0101, '0);
    @(negedge clk);
    req_valid = 1'b1; req_po = 6'd34; req_addr = 16'h0101; req_wdata = '0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) req_valid = 1'b0;
      if (c == 1) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b want 0", req_ready); end
      end
      if (resp_valid) begin
        if (pulses < 4) at[pulses] = c;
        pulses++;
        checks++; if (resp_rdata !== e_rdata) begin errors++; $display("FAIL b2b_data: got %h want %h", resp_rdata, e_rdata); end
      end
    end
    checks++; if (pulses !== 3 || at[0] !== 3 || at[1] !== 7 || at[2] !== 11) begin errors++;
      $display("FAIL b2b_timing: pulses=%0d at %0d,%0d,%0d want 3 at 3,7,11", pulses, at[0], at[1], at[2]); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    logic [5:0]  pos [9] = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd58, 6'd38, 6'd44, 6'd36, 6'd62};
    logic [5:0]  po;
    logic [15:0] addr;
    logic [63:0] wd;
    int sel;
    for (int it = 0; it < 300; it++) begin
      sel  = int'($urandom_range(0, 9));
      po   = (sel == 9) ? 6'($urandom) : pos[sel];
      addr = 16'($urandom);
      wd   = {$urandom, $urandom};
      model_op(po, addr, wd);
      do_op(po, addr, wd);
      checks++; if (obs_lat !== e_lat) begin errors++; $display("FAIL rnd_latency po=%0d addr=%h: got %0d want %0d", po, addr, obs_lat, e_lat); end
      checks++; if (obs_err !== e_err || obs_rdata !== e_rdata) begin errors++;
        $display("FAIL rnd_resp po=%0d addr=%h: rdata=%h err=%b want %h/%b", po, addr, obs_rdata, obs_err, e_rdata, e_err); end
      checks++; if (obs_nbeats !== e_nbeats) begin errors++; $display("FAIL rnd_nbeats po=%0d addr=%h: got %0d want %0d", po, addr, obs_nbeats, e_nbeats); end
      if (e_nbeats >= 1 && obs_nbeats >= 1) begin
        checks++; if (obs_idx[0] !== e_idx0 || obs_be[0] !== e_be0 || obs_we[0] !== e_store) begin errors++;
          $display("FAIL rnd_beat0 po=%0d addr=%h: idx=%h be=%h we=%b want %h/%h/%b", po, addr, obs_idx[0], obs_be[0], obs_we[0], e_idx0, e_be0, e_store); end
        if (e_store) begin
          checks++; if (ram[e_idx0] !== ref_dw(int'(e_idx0))) begin errors++;
            $display("FAIL rnd_ram0 addr=%h: got %h want %h", addr, ram[e_idx0], ref_dw(int'(e_idx0))); end
        end
      end
      if (e_nbeats == 2 && obs_nbeats >= 2) begin
        checks++; if (obs_idx[1] !== e_idx1 || obs_be[1] !== e_be1 || obs_we[1] !== e_store) begin errors++;
          $display("FAIL rnd_beat1 po=%0d addr=%h: idx=%h be=%h we=%b want %h/%h/%b", po, addr, obs_idx[1], obs_be[1], obs_we[1], e_idx1, e_be1, e_store); end
        if (e_store) begin
          checks++; if (ram[e_idx1] !== ref_dw(int'(e_idx1))) begin errors++;
            $display("FAIL rnd_ram1 addr=%h: got %h want %h", addr, ram[e_idx1], ref_dw(int'(e_idx1))); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) set_dw(i, {$urandom, $urandom});
    test_reset();
    test_aligned_ld();
    test_half_ext();
    test_split_stw();
    test_split_ld_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
